uart_tx_stream: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable frame format, and back-to-back frame transmission. It replaces the fixed 8N1 single-byte transmitter on the board's serial debug/console path. Producers push words through a valid/ready handshake, and the block serialises them onto `tx` at `CLKS_PER_BIT` clocks per bit with no idle gap between queued frames.

---
 rtl/uart_tx_stream.sv | 149 ++++++++++++++
 tb/tb_uart_tx_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: input FIFO, configurable frame, back-to-back frames.
// Optional parity bit is compiled in with `define UART_TX_STREAM_PARITY_EN.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               CLK100MHZ,
    input  logic                               reset,
    input  logic                               tx_valid,
    input  logic [DATA_BITS-1:0]               tx_data,
    output logic                               tx_ready,
    input  logic                               parity_odd,
    output logic                               tx,
    output logic                               tx_idle,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT-1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS-1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_count;

    state_t               r_state;
    logic [15:0]          r_timer;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;

    logic                 w_push, w_pop, w_have, w_bit_end, w_last_stop;
    logic [IDX_W-1:0]     w_idx_nxt;

    assign tx_ready    = (r_count != CNT_FULL);
    assign w_push      = tx_valid && tx_ready;
    assign w_have      = (r_count != '0);
    assign w_bit_end   = (r_timer == BIT_LAST);
    assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
    assign w_idx_nxt   = r_idx + IDX_W'(1);
    // Pop happens on the same edge that enters START, so frames abut with no gap.
    assign w_pop       = w_have && ((r_state == S_IDLE) ||
                                    (r_state == S_STOP && w_bit_end && w_last_stop));

    assign tx          = r_tx;
    assign tx_idle     = (r_state == S_IDLE) && !w_have;
    assign fifo_count  = r_count;

`ifdef UART_TX_STREAM_PARITY_EN
    logic r_par_odd;
    logic w_parity;
    assign w_parity = (^r_shift) ^ r_par_odd;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (w_push) r_mem[r_wptr] <= tx_data;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_STREAM_PARITY_EN
            r_par_odd  <= 1'b0;
`endif
        end else begin
            r_timer <= (r_state == S_IDLE || w_bit_end) ? 16'd0 : r_timer + 16'd1;
            if (w_pop) begin
                r_shift    <= r_mem[r_rptr];
                r_state    <= S_START;
                r_tx       <= 1'b0;
                r_timer    <= '0;
`ifdef UART_TX_STREAM_PARITY_EN
                r_par_odd  <= parity_odd;
`endif
            end else begin
                case (r_state)
                    S_START: if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: if (w_bit_end) begin
                        if (r_idx == IDX_LAST) begin
`ifdef UART_TX_STREAM_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= w_parity;
`else
                            r_state    <= S_STOP;
                            r_stop_cnt <= 1'b0;
                            r_tx       <= 1'b1;
`endif
                        end else begin
                            r_idx <= w_idx_nxt;
                            r_tx  <= r_shift[w_idx_nxt];
                        end
                    end
                    S_PARITY: if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b1;
                    end
                    S_STOP: if (w_bit_end) begin
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: table vectors plus multi-cycle sequences, checked by a frame monitor/scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_stream;
    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_STREAM_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL  = (1 + DB + P + SB) * CPB;
    localparam int FL2 = (1 + 7 + P + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       v, po, rdy, tx, idle;
    logic [7:0] dat;
    logic [2:0] cnt;
    logic       v2, rdy2, tx2, idle2;
    logic [6:0] d2;
    logic [2:0] cnt2;

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(4)) dut (
        .CLK100MHZ(clk), .reset(rst), .tx_valid(v), .tx_data(dat), .tx_ready(rdy),
        .parity_odd(po), .tx(tx), .tx_idle(idle), .fifo_count(cnt));

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .CLK100MHZ(clk), .reset(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(rdy2),
        .parity_odd(po), .tx(tx2), .tx_idle(idle2), .fifo_count(cnt2));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [7:0] d; logic par; } exp_t;
    typedef struct { logic [7:0] d; logic po; logic par; } vec_t;
    exp_t  exp_q[$];
    vec_t  tbl[7];
    int    checks = 0, errors = 0;
    logic  m_busy = 1'b0;
    int    m_n = 0, m_frames = 0;
    int    m_start[$];
    logic [63:0] m_wave;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Expected per-cycle line waveform for one 8-bit frame, bit 0 = first cycle.
    function automatic logic [63:0] model_wave(input logic [7:0] d, input logic par);
        logic [15:0] fb;
        logic [63:0] w;
        int k;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < DB; i++) fb[i+1] = d[i];
        if (P == 1) fb[DB+1] = par;
        w = '0;
        k = 0;
        for (int b = 0; b < 1 + DB + P + SB; b++)
            for (int c = 0; c < CPB; c++) begin w[k] = fb[b]; k++; end
        return w;
    endfunction

    task automatic check_frame();
        exp_t e;
        logic [63:0] w;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got wave %h, required no frame", m_wave);
        end else begin
            e = exp_q.pop_front();
            w = model_wave(e.d, e.par);
            if (m_wave !== w) begin
                errors++;
                $display("FAIL frame_%02h: got wave %h required %h", e.d, m_wave, w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) m_busy = 1'b0;
        else begin
            if (!m_busy && tx == 1'b0) begin
                m_busy = 1'b1; m_n = 0; m_wave = '0; m_frames++;
                m_start.push_back(cyc);
            end
            if (m_busy) begin
                m_wave[m_n] = tx;
                m_n++;
                if (m_n == FL) begin m_busy = 1'b0; check_frame(); end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic par, output logic stalled);
        int n;
        stalled = 1'b0;
        @(negedge clk);
        v = 1'b1; dat = d;
        n = 0;
        while (!rdy && n < 500) begin stalled = 1'b1; @(negedge clk); n++; end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL push_timeout: got tx_ready 0 required 1");
            v = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back('{d, par});
            #1 v = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle && !m_busy) && n < 2000) begin @(negedge clk); n++; end
        chk({name, "_idle"}, {31'd0, idle && !m_busy}, 32'd1);
        chk({name, "_q_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        int base, sidx, n;
        logic [63:0] got2, exp2;
        logic [15:0] fb2;
        tbl[0] = '{8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1};
        tbl[2] = '{8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1};
        tbl[4] = '{8'h55, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b0, 1'b1};

        rst = 1'b1; v = 1'b0; dat = '0; po = 1'b0; v2 = 1'b0; d2 = '0;
        #22;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, rdy}, 32'd1);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_count", {29'd0, cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            po = tbl[i].po;
            push(tbl[i].d, tbl[i].par, st);
            chk("vec_count", {29'd0, cnt}, 32'd1);
            chk("vec_tx_before_pop", {31'd0, tx}, 32'd1);
            @(posedge clk); #1;
            chk("vec_tx_start", {31'd0, tx}, 32'd0);
            wait_idle("vec");
        end

        // back-to-back frames with no idle gap
        po = 1'b0;
        sidx = m_start.size();
        base = m_frames;
        push(8'h00, 1'b0, st); chk("b2b_cnt_a", {29'd0, cnt}, 32'd1);
        push(8'hFF, 1'b0, st); chk("b2b_cnt_b", {29'd0, cnt}, 32'd1);
        push(8'h55, 1'b0, st); chk("b2b_cnt_c", {29'd0, cnt}, 32'd2);
        n = 0;
        while (m_frames < base + 2 && n < 500) begin @(negedge clk); n++; end
        chk("b2b_cnt_after_pop", {29'd0, cnt}, 32'd1);
        wait_idle("b2b");
        chk("b2b_frames", m_start.size() - sidx, 32'd3);
        if (m_start.size() - sidx >= 3) begin
            chk("b2b_gap1", m_start[sidx+1] - m_start[sidx], FL);
            chk("b2b_gap2", m_start[sidx+2] - m_start[sidx+1], FL);
        end

        // full FIFO: producer stalls, nothing lost
        for (int k = 0; k < 6; k++) begin
            push(8'h10 + 8'(k), ^(8'h10 + 8'(k)), st);
            if (k == 4) begin
                chk("full_count", {29'd0, cnt}, 32'd4);
                chk("full_ready", {31'd0, rdy}, 32'd0);
            end
            if (k == 5) chk("full_stalled", {31'd0, st}, 32'd1);
        end
        wait_idle("full");

        // second format: 7 data bits, 2 stop bits
        @(negedge clk); v2 = 1'b1; d2 = 7'h41;
        @(posedge clk); #1 v2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (tx2 && n < 50) begin @(negedge clk); n++; end
        got2 = '0;
        for (int c = 0; c < FL2; c++) begin got2[c] = tx2; @(negedge clk); end
        fb2 = '1;
        fb2[0] = 1'b0;
        for (int i = 0; i < 7; i++) fb2[i+1] = d2[i];
        if (P == 1) fb2[8] = ^d2 ^ po;
        exp2 = '0;
        for (int b = 0; b < 1 + 7 + P + 2; b++)
            for (int c = 0; c < CPB; c++) exp2[b*CPB + c] = fb2[b];
        checks++;
        if (got2 !== exp2) begin
            errors++;
            $display("FAIL fmt7e2_wave: got %h required %h", got2, exp2);
        end
        chk("fmt7e2_idle", {31'd0, idle2}, 32'd1);
        chk("fmt7e2_tx_high", {31'd0, tx2}, 32'd1);

        // asynchronous reset in the middle of a frame with words queued
        push(8'h3C, ^8'h3C, st);
        push(8'hC3, ^8'hC3, st);
        push(8'h5A, ^8'h5A, st);
        chk("rstmid_count", {29'd0, cnt}, 32'd2);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        chk("rstmid_count0", {29'd0, cnt}, 32'd0);
        chk("rstmid_idle", {31'd0, idle}, 32'd1);
        chk("rstmid_ready", {31'd0, rdy}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = m_frames;
        repeat (200) @(negedge clk);
        chk("rstmid_no_frames", m_frames, base);
        chk("rstmid_tx_after", {31'd0, tx}, 32'd1);
        chk("rstmid_idle_after", {31'd0, idle}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
